// File: rtl/npu_act_mem_arb.sv
// Activation-memory arbiter: datapath write > operand read > host write onto one 1-cycle-latency BRAM.
// Optional build macro NPU_ACT_MEM_RANGE_CHECK_EN blocks out-of-range accesses and raises a sticky addr_err.
module npu_act_mem_arb #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned DATA_WIDTH    = 8
`ifdef NPU_ACT_MEM_RANGE_CHECK_EN
  ,
  parameter int unsigned ACT_MEM_DEPTH = 3872
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hw_mem_wr,
  input  logic [ADDR_WIDTH-1:0] hw_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] hw_mem_wr_data,
  output logic                  hw_mem_wr_ack_p,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid_p,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ack_p,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  addr_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACC,
    ST_RD_ACC,
    ST_RD_CAP,
    ST_RD_DONE
  } state_e;

  state_e                state_q;
  logic                  hw_ack_q;
  logic                  host_ack_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  busy_q;
  logic                  rd_oor_q;

  // Per-requester out-of-range flags; constant 0 when the check is not built.
  logic hw_oor_c;
  logic rd_oor_c;
  logic host_oor_c;

`ifdef NPU_ACT_MEM_RANGE_CHECK_EN
  logic addr_err_q;

  assign hw_oor_c   = 32'(hw_mem_wr_addr) >= ACT_MEM_DEPTH;
  assign rd_oor_c   = 32'(rd_addr)        >= ACT_MEM_DEPTH;
  assign host_oor_c = 32'(host_wr_addr)   >= ACT_MEM_DEPTH;
  assign addr_err   = addr_err_q;

  // Sticky error: any granted out-of-range access sets it until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (hw_mem_wr) begin
        if (hw_oor_c) addr_err_q <= 1'b1;
      end else if (rd_req) begin
        if (rd_oor_c) addr_err_q <= 1'b1;
      end else if (host_wr) begin
        if (host_oor_c) addr_err_q <= 1'b1;
      end
    end
  end
`else
  assign hw_oor_c   = 1'b0;
  assign rd_oor_c   = 1'b0;
  assign host_oor_c = 1'b0;
  assign addr_err   = 1'b0;
`endif

  // Arbitration FSM; every port-facing output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hw_ack_q    <= 1'b0;
      host_ack_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      hw_ack_q   <= 1'b0;
      host_ack_q <= 1'b0;
      rd_valid_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hw_mem_wr) begin
            state_q     <= ST_WR_ACC;
            busy_q      <= 1'b1;
            mem_en_q    <= ~hw_oor_c;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= hw_mem_wr_addr;
            mem_wdata_q <= hw_mem_wr_data;
            hw_ack_q    <= 1'b1;
          end else if (rd_req) begin
            state_q    <= ST_RD_ACC;
            busy_q     <= 1'b1;
            mem_en_q   <= ~rd_oor_c;
            mem_addr_q <= rd_addr;
            rd_oor_q   <= rd_oor_c;
          end else if (host_wr) begin
            state_q     <= ST_WR_ACC;
            busy_q      <= 1'b1;
            mem_en_q    <= ~host_oor_c;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= host_wr_addr;
            mem_wdata_q <= host_wr_data;
            host_ack_q  <= 1'b1;
          end
        end
        ST_WR_ACC: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_RD_ACC: begin
          state_q <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          // Blocked reads never touched the BRAM, so return zero instead of stale rdata.
          rd_data_q  <= rd_oor_q ? '0 : mem_rdata;
          rd_valid_q <= 1'b1;
          state_q    <= ST_RD_DONE;
        end
        ST_RD_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hw_mem_wr_ack_p = hw_ack_q;
  assign host_wr_ack_p   = host_ack_q;
  assign rd_valid_p      = rd_valid_q;
  assign rd_data         = rd_data_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_npu_act_mem_arb.sv
// Directed bench for npu_act_mem_arb with a 1-cycle-latency BRAM model behind the memory port.
module tb_npu_act_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        hw_mem_wr;
  logic [11:0] hw_mem_wr_addr;
  logic [7:0]  hw_mem_wr_data;
  logic        hw_mem_wr_ack_p;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid_p;
  logic        host_wr;
  logic [11:0] host_wr_addr;
  logic [7:0]  host_wr_data;
  logic        host_wr_ack_p;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        addr_err;

  int total;
  int bad;
  int hw_acks;
  int host_acks;
  int rd_valids;

  logic [7:0] tbmem [0:4095];

  npu_act_mem_arb dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hw_mem_wr       (hw_mem_wr),
    .hw_mem_wr_addr  (hw_mem_wr_addr),
    .hw_mem_wr_data  (hw_mem_wr_data),
    .hw_mem_wr_ack_p (hw_mem_wr_ack_p),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid_p      (rd_valid_p),
    .host_wr         (host_wr),
    .host_wr_addr    (host_wr_addr),
    .host_wr_data    (host_wr_data),
    .host_wr_ack_p   (host_wr_ack_p),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .busy            (busy),
    .addr_err        (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port BRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  // Pulse counters, sampled mid-cycle so each one-cycle pulse counts once.
  always @(negedge clk) begin
    if (hw_mem_wr_ack_p === 1'b1) hw_acks++;
    if (host_wr_ack_p === 1'b1) host_acks++;
    if (rd_valid_p === 1'b1) rd_valids++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {hw_mem_wr_ack_p, host_wr_ack_p, rd_valid_p, mem_en, mem_we, busy, addr_err,
            5'(0), rd_data, mem_addr[7:0], mem_wdata};
  endfunction

  initial begin
    logic [2:0] exp_seq [1:8];
    int         b_hw, b_rd, b_host, errs;
    total = 0; bad = 0; hw_acks = 0; host_acks = 0; rd_valids = 0;
    rst_n = 1'b0;
    hw_mem_wr = 1'b0; hw_mem_wr_addr = '0; hw_mem_wr_data = '0;
    rd_req = 1'b0; rd_addr = '0;
    host_wr = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    for (int i = 0; i < 4096; i++) tbmem[i] = 8'h00;

    // Reset state
    tick(); tick();
    chk("reset_outs", outs_vec(), 32'h0);
    chk("reset_mem_addr_hi", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs_vec(), 32'h0);

    // Single datapath write, ack one cycle after request
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h100; hw_mem_wr_data = 8'h5A;
    tick();
    chk("wr_ctl", 32'({hw_mem_wr_ack_p, mem_en, mem_we, busy, host_wr_ack_p, rd_valid_p}), 32'b111100);
    chk("wr_addr", 32'(mem_addr), 32'h100);
    chk("wr_data", 32'(mem_wdata), 32'h5A);
    hw_mem_wr = 1'b0;
    tick();
    chk("wr_after", 32'({hw_mem_wr_ack_p, mem_en, mem_we, busy}), 32'b0000);
    chk("wr_addr_hold", 32'(mem_addr), 32'h100);
    chk("wr_mem", 32'(tbmem[12'h100]), 32'h5A);
    chk("wr_ack_count", 32'(hw_acks), 32'd1);

    // Preload 0x3C at 0x020, then read it back
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h020; hw_mem_wr_data = 8'h3C;
    tick();
    hw_mem_wr = 1'b0;
    tick();
    rd_req = 1'b1; rd_addr = 12'h020;
    tick();
    chk("rd_acc", 32'({mem_en, mem_we, rd_valid_p, busy}), 32'b1001);
    chk("rd_acc_addr", 32'(mem_addr), 32'h020);
    tick();
    chk("rd_cap", 32'({mem_en, rd_valid_p, busy}), 32'b001);
    tick();
    chk("rd_valid", 32'({rd_valid_p, busy}), 32'b11);
    chk("rd_data", 32'(rd_data), 32'h3C);
    rd_req = 1'b0;
    tick();
    chk("rd_after", 32'({rd_valid_p, busy, mem_en}), 32'b000);
    tick();
    chk("rd_data_hold", 32'(rd_data), 32'h3C);

    // Simultaneous requests: hw write, then read, then host write
    b_hw = hw_acks; b_rd = rd_valids; b_host = host_acks;
    exp_seq[1] = 3'b100; exp_seq[2] = 3'b000; exp_seq[3] = 3'b000; exp_seq[4] = 3'b000;
    exp_seq[5] = 3'b010; exp_seq[6] = 3'b000; exp_seq[7] = 3'b001; exp_seq[8] = 3'b000;
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h010; hw_mem_wr_data = 8'h11;
    rd_req = 1'b1; rd_addr = 12'h100;
    host_wr = 1'b1; host_wr_addr = 12'h200; host_wr_data = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("sim_pulses_c%0d", k), 32'({hw_mem_wr_ack_p, rd_valid_p, host_wr_ack_p}),
          32'(exp_seq[k]));
      if (k == 1) hw_mem_wr = 1'b0;
      if (k == 5) begin
        chk("sim_rd_data", 32'(rd_data), 32'h5A);
        rd_req = 1'b0;
      end
      if (k == 7) begin
        chk("sim_host_addr", 32'(mem_addr), 32'h200);
        host_wr = 1'b0;
      end
    end
    chk("sim_counts", 32'({8'(hw_acks - b_hw), 8'(rd_valids - b_rd), 8'(host_acks - b_host)}),
        32'h010101);
    chk("sim_mem_hw", 32'(tbmem[12'h010]), 32'h11);
    chk("sim_mem_host", 32'(tbmem[12'h200]), 32'h22);

    // Back-to-back datapath writes, 2-cycle period
    b_hw = hw_acks;
    for (int i = 0; i < 16; i++) begin
      hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'(i); hw_mem_wr_data = 8'(8'h80 + i);
      tick();
      chk($sformatf("b2b_ack_%0d", i), 32'({hw_mem_wr_ack_p, mem_we, 4'(mem_addr)}),
          32'({2'b11, 4'(i)}));
      if (i == 15) hw_mem_wr = 1'b0;
      tick();
      chk($sformatf("b2b_idle_%0d", i), 32'({hw_mem_wr_ack_p, busy}), 32'b00);
    end
    errs = 0;
    for (int i = 0; i < 16; i++) if (tbmem[i] !== 8'(8'h80 + i)) errs++;
    chk("b2b_mem_errs", 32'(errs), 32'd0);
    chk("b2b_ack_count", 32'(hw_acks - b_hw), 32'd16);

    // Async reset during RD_CAP
    b_rd = rd_valids;
    rd_req = 1'b1; rd_addr = 12'h020;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs_vec(), 32'h0);
    rd_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rst_no_valid", 32'(rd_valids - b_rd), 32'd0);
    chk("rst_idle_outs", outs_vec(), 32'h0);
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'h030; hw_mem_wr_data = 8'hA5;
    tick();
    chk("rst_then_wr", 32'({hw_mem_wr_ack_p, mem_en, mem_we}), 32'b111);
    hw_mem_wr = 1'b0;
    tick();

    // Out-of-range write
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'hF20; hw_mem_wr_data = 8'h77;
    tick();
`ifdef NPU_ACT_MEM_RANGE_CHECK_EN
    chk("oor_wr", 32'({hw_mem_wr_ack_p, mem_en, addr_err}), 32'b101);
`else
    chk("oor_wr", 32'({hw_mem_wr_ack_p, mem_en, addr_err}), 32'b110);
`endif
    hw_mem_wr = 1'b0;
    tick(); tick();
`ifdef NPU_ACT_MEM_RANGE_CHECK_EN
    chk("oor_sticky", 32'({addr_err, busy}), 32'b10);
    chk("oor_mem_untouched", 32'(tbmem[12'hF20] === 8'h77), 32'd0);
`else
    chk("oor_sticky", 32'({addr_err, busy}), 32'b00);
    chk("oor_mem_written", 32'(tbmem[12'hF20]), 32'h77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
